control_cmd_dispatch: RTL and testbench
=======================================

# control_cmd_dispatch

Command sequencer between the UART byte receiver and the control-command handlers, including the watchdog signature handler. It decodes the first byte of each command as an opcode and selects exactly one handler. It then forwards the command's fixed-length payload to that handler as one-cycle enable strobes and waits for the handler's `done`. Unknown opcodes, stalled payloads, hung handlers and bytes arriving while a handler is finishing all raise error pulses and return the block to idle.

## Interface
Parameters:
- `NUM_HANDLERS`, default `params::CMD_NUM_HANDLERS` (4): number of handler slots.
- `TIMEOUT_TICKS`, default `params::CMD_TIMEOUT_TICKS` (100000): clocks allowed between payload bytes, and clocks allowed for a handler to assert `done`.

Ports:
- `clk`, input, 1: the single clock.
- `reset`, input, 1: synchronous, active-high; sampled on posedge `clk`.
- `data_in`, input, 8: received byte.
- `data_valid`, input, 1: `data_in` is valid this cycle (single-cycle strobe per byte).
- `handler_done`, input, `NUM_HANDLERS`: per-handler done pulse.
- `handler_enable`, output, `NUM_HANDLERS`: one-hot strobe, one cycle per forwarded payload byte.
- `handler_data`, output, 8: registered payload byte, valid while `handler_enable` is set.
- `busy`, output, 1: high in any state other than IDLE.
- `cmd_done`, output, 1: one-cycle pulse when a command completes.
- `error_unknown`, `error_timeout`, `error_overrun`, outputs, 1 each: one-cycle error pulses.

## Operation
- States (`cmd_dispatch_state_t`): IDLE, PAYLOAD, WAIT_DONE.
- **IDLE**, on `data_valid`:
  - Compare `data_in` against `params::CMD_OPCODES[k]`.
  - Lowest matching `k` wins: latch `sel<=k`, `remaining<=params::CMD_PAYLOAD_BYTES[k]`, go to PAYLOAD.
  - No match: pulse `error_unknown`, stay in IDLE.
- **PAYLOAD**, on `data_valid`:
  - Register `handler_data<=data_in` and `handler_enable<=1<<sel`.
  - Decrement `remaining`; when `remaining==1` at this byte, go to WAIT_DONE.
- **WAIT_DONE**:
  - `handler_done[sel]` completes the command: pulse `cmd_done`, go to IDLE.
  - `handler_done` bits for other handlers are ignored in every state.
- **Timeout**: `tmo` counter.
  - Loaded with `TIMEOUT_TICKS` on entry to PAYLOAD, on every accepted payload byte, and on entry to WAIT_DONE.
  - Decrements by 1 each cycle otherwise.
  - Reaching 0 in PAYLOAD or WAIT_DONE: pulse `error_timeout`, go to IDLE, no `cmd_done`.
- **Overrun**: `data_valid` in WAIT_DONE drops the byte and pulses `error_overrun`.
- **Simultaneous events**:
  - `handler_done[sel]` and `data_valid` in WAIT_DONE: `cmd_done` and `error_overrun` pulse together; go to IDLE.
  - `data_valid` and `tmo==0` in PAYLOAD: the byte is accepted and the counter reloads; no timeout.
  - `handler_done[sel]` and `tmo==0` in WAIT_DONE: done wins; no timeout.
- **Arithmetic and widths**:
  - `remaining` is 8 bits. Package payload lengths are 1..255; length 0 is illegal, enforced by package assertion.
  - `tmo` is `$clog2(TIMEOUT_TICKS+1)` bits, with explicit width casts on load.
  - `sel` is `$clog2(NUM_HANDLERS)` bits, minimum 1.

## Timing
- Reset values: state IDLE; all of the following zero: `handler_enable`, `handler_data`, `busy`, `cmd_done`, all `error_*`, `remaining`, `sel`.
- Reset mid-command abandons it: no `cmd_done`, no error pulse, no further enables.
- Opcode byte at cycle t: `busy` goes high at t+1.
- Payload byte at cycle t: `handler_enable`/`handler_data` appear at t+1, for exactly one cycle.
- Command completion: `handler_done[sel]` at cycle t gives `cmd_done` at t+1, with `busy` low at t+1.
- All error pulses are registered, one cycle after the causing event.
- Back-to-back bytes (`data_valid` every cycle) are accepted without loss in IDLE and PAYLOAD.
- A new opcode is accepted on the cycle after `cmd_done` pulses.

## Configuration
- `CONTROL_CMD_DISPATCH_TIMEOUT_EN` defined: timeout counter and `error_timeout` behave as specified above.
- Not defined:
  - No `tmo` logic is generated and `error_timeout` is tied to 0.
  - PAYLOAD and WAIT_DONE wait indefinitely; only `reset` recovers a stalled command.

## Structure
- Package `params` holds:
  - `CMD_NUM_HANDLERS` and `CMD_TIMEOUT_TICKS`.
  - `CMD_OPCODES[CMD_NUM_HANDLERS]` (8-bit each) and `CMD_PAYLOAD_BYTES[CMD_NUM_HANDLERS]`.
  - Typedef `cmd_dispatch_state_t`.
- Slot 0 is the watchdog: opcode 0x57, payload `WATCHDOG_SIGNATURE_BITS/8` bytes.
- One sub-module, `cmd_timeout_counter`: load/decrement/zero-flag counter, instantiated only under the macro.

## Test plan
- Watchdog command: reset, then send 0x57 followed by 4 bytes. Expect 4 single-cycle `handler_enable==4'b0001` strobes carrying the same bytes, `busy` high throughout. Drive `handler_done[0]` 1 cycle after the last strobe; expect `cmd_done` one cycle later.
- Unknown opcode: send 0xFF. Expect one `error_unknown` pulse, `busy` stays 0, no enables.
- Inter-byte timeout (macro on, `TIMEOUT_TICKS=16`): send 0x57 plus 2 bytes, then idle. Expect `error_timeout` 17 cycles after the last byte, then IDLE, then 0x57 accepted again.
- Overrun: complete a 4-byte payload and hold `handler_done` low. Send 1 byte; expect `error_overrun`. Then assert `handler_done[0]`; expect `cmd_done`.
- Misrouted done: during WAIT_DONE for slot 0, pulse `handler_done[1]`. Expect no `cmd_done` and state unchanged.
- Reset mid-payload: after 0x57 plus 1 byte, assert `reset` for 1 cycle. Expect all outputs 0 and no `cmd_done`; a new full 0x57 command then succeeds.

Source files
------------

// File: rtl/control_cmd_dispatch_pkg.sv
// Shared constants for the command dispatcher: handler table, timeout default and FSM state type.
package params;

  localparam int CMD_NUM_HANDLERS        = 4;
  localparam int CMD_TIMEOUT_TICKS       = 100000;
  localparam int WATCHDOG_SIGNATURE_BITS = 32;

  // Slot 0 is the watchdog signature handler.
  localparam logic [CMD_NUM_HANDLERS-1:0][7:0] CMD_OPCODES =
    {8'h43, 8'h42, 8'h41, 8'h57};
  localparam logic [CMD_NUM_HANDLERS-1:0][7:0] CMD_PAYLOAD_BYTES =
    {8'd3, 8'd2, 8'd1, 8'(WATCHDOG_SIGNATURE_BITS / 8)};

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    WAIT_DONE
  } cmd_dispatch_state_t;

  function automatic bit payload_lengths_legal();
    for (int k = 0; k < CMD_NUM_HANDLERS; k++) begin
      if (CMD_PAYLOAD_BYTES[k] == 8'd0) return 1'b0;
    end
    return 1'b1;
  endfunction

endpackage

// File: rtl/control_cmd_dispatch_timeout_counter.sv
// Reloadable down-counter with a zero flag; saturates at zero until the next load.
module cmd_timeout_counter #(
  parameter int TICKS = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic zero
);

  localparam int W = $clog2(TICKS + 1);

  logic [W-1:0] tmo_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_reg <= W'(TICKS);
    end else if (load) begin
      tmo_reg <= W'(TICKS);
    end else if (tmo_reg != '0) begin
      tmo_reg <= tmo_reg - W'(1);
    end
  end

  assign zero = (tmo_reg == '0);

endmodule

// File: rtl/control_cmd_dispatch.sv
// Opcode decoder / payload forwarder between the UART receiver and the command handlers.
// Optional watchdog on stalled payloads and hung handlers: CONTROL_CMD_DISPATCH_TIMEOUT_EN.
module control_cmd_dispatch
  import params::*;
#(
  parameter int NUM_HANDLERS  = CMD_NUM_HANDLERS,
  parameter int TIMEOUT_TICKS = CMD_TIMEOUT_TICKS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              data_in,
  input  logic                    data_valid,
  input  logic [NUM_HANDLERS-1:0] handler_done,
  output logic [NUM_HANDLERS-1:0] handler_enable,
  output logic [7:0]              handler_data,
  output logic                    busy,
  output logic                    cmd_done,
  output logic                    error_unknown,
  output logic                    error_timeout,
  output logic                    error_overrun
);

  localparam int SEL_W = (NUM_HANDLERS > 1) ? $clog2(NUM_HANDLERS) : 1;

  if (!payload_lengths_legal()) begin : g_bad_payload_len
    $error("params::CMD_PAYLOAD_BYTES contains a zero-length entry");
  end
  if (NUM_HANDLERS > CMD_NUM_HANDLERS || NUM_HANDLERS < 1) begin : g_bad_handlers
    $error("NUM_HANDLERS must be 1..params::CMD_NUM_HANDLERS");
  end
  if (TIMEOUT_TICKS < 1) begin : g_bad_timeout
    $error("TIMEOUT_TICKS must be at least 1");
  end

  cmd_dispatch_state_t     state_reg, state_next;
  logic [SEL_W-1:0]        sel_reg, sel_next;
  logic [7:0]              remaining_reg, remaining_next;
  logic [NUM_HANDLERS-1:0] enable_reg, enable_next;
  logic [7:0]              data_reg, data_next;
  logic                    cmd_done_reg, cmd_done_next;
  logic                    unknown_reg, unknown_next;
  logic                    overrun_reg, overrun_next;

  logic [NUM_HANDLERS-1:0] match;
  logic                    match_any;
  logic [SEL_W-1:0]        match_sel;
  logic                    sel_done;
  logic                    tmo_fire;

  for (genvar gi = 0; gi < NUM_HANDLERS; gi++) begin : g_match
    assign match[gi] = (data_in == CMD_OPCODES[gi]);
  end

  // Scan from the top so the lowest matching slot is the one left standing.
  always_comb begin
    match_any = 1'b0;
    match_sel = '0;
    for (int k = NUM_HANDLERS - 1; k >= 0; k--) begin
      if (match[k]) begin
        match_any = 1'b1;
        match_sel = SEL_W'(k);
      end
    end
  end

  assign sel_done = handler_done[sel_reg];

`ifdef CONTROL_CMD_DISPATCH_TIMEOUT_EN
  logic tmo_load;
  logic tmo_zero;
  logic timeout_reg;

  assign tmo_load = (state_reg == IDLE && data_valid && match_any) ||
                    (state_reg == PAYLOAD && data_valid);

  cmd_timeout_counter #(
    .TICKS (TIMEOUT_TICKS)
  ) u_tmo (
    .clk   (clk),
    .reset (reset),
    .load  (tmo_load),
    .zero  (tmo_zero)
  );

  // An accepted byte or the selected done on the expiry cycle beats the timeout.
  assign tmo_fire = tmo_zero &&
                    ((state_reg == PAYLOAD && !data_valid) ||
                     (state_reg == WAIT_DONE && !sel_done));

  always_ff @(posedge clk) begin
    if (reset) timeout_reg <= 1'b0;
    else       timeout_reg <= tmo_fire;
  end

  assign error_timeout = timeout_reg;
`else
  assign tmo_fire      = 1'b0;
  assign error_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      sel_reg       <= '0;
      remaining_reg <= '0;
      enable_reg    <= '0;
      data_reg      <= '0;
      cmd_done_reg  <= 1'b0;
      unknown_reg   <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sel_reg       <= sel_next;
      remaining_reg <= remaining_next;
      enable_reg    <= enable_next;
      data_reg      <= data_next;
      cmd_done_reg  <= cmd_done_next;
      unknown_reg   <= unknown_next;
      overrun_reg   <= overrun_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    sel_next       = sel_reg;
    remaining_next = remaining_reg;
    unique case (state_reg)
      IDLE: begin
        if (data_valid && match_any) begin
          state_next     = PAYLOAD;
          sel_next       = match_sel;
          remaining_next = CMD_PAYLOAD_BYTES[match_sel];
        end
      end
      PAYLOAD: begin
        if (data_valid) begin
          remaining_next = remaining_reg - 8'd1;
          if (remaining_reg == 8'd1) state_next = WAIT_DONE;
        end else if (tmo_fire) begin
          state_next = IDLE;
        end
      end
      WAIT_DONE: begin
        if (sel_done || tmo_fire) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    enable_next   = '0;
    data_next     = data_reg;
    cmd_done_next = 1'b0;
    unknown_next  = 1'b0;
    overrun_next  = 1'b0;
    unique case (state_reg)
      IDLE: unknown_next = data_valid && !match_any;
      PAYLOAD: begin
        if (data_valid) begin
          enable_next = NUM_HANDLERS'(1) << sel_reg;
          data_next   = data_in;
        end
      end
      WAIT_DONE: begin
        cmd_done_next = sel_done;
        overrun_next  = data_valid;
      end
      default: ;
    endcase
  end

  assign busy           = (state_reg != IDLE);
  assign handler_enable = enable_reg;
  assign handler_data   = data_reg;
  assign cmd_done       = cmd_done_reg;
  assign error_unknown  = unknown_reg;
  assign error_overrun  = overrun_reg;

endmodule

// File: tb/tb_control_cmd_dispatch.sv
// Directed bench for control_cmd_dispatch; the timeout scenario runs when
// CONTROL_CMD_DISPATCH_TIMEOUT_EN is defined, otherwise an indefinite-stall scenario runs.
module tb_control_cmd_dispatch;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic [3:0] handler_done = 4'b0000;
  logic [3:0] handler_enable;
  logic [7:0] handler_data;
  logic       busy, cmd_done, error_unknown, error_timeout, error_overrun;

  int checks = 0;
  int errors = 0;

  logic [7:0] sig [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

  control_cmd_dispatch #(
    .NUM_HANDLERS  (4),
    .TIMEOUT_TICKS (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .data_in        (data_in),
    .data_valid     (data_valid),
    .handler_done   (handler_done),
    .handler_enable (handler_enable),
    .handler_data   (handler_data),
    .busy           (busy),
    .cmd_done       (cmd_done),
    .error_unknown  (error_unknown),
    .error_timeout  (error_timeout),
    .error_overrun  (error_overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_byte(input logic [7:0] b);
    data_in    = b;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({handler_enable, handler_data, busy, cmd_done, error_unknown, error_timeout, error_overrun} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs got en=%b data=%h busy=%b done=%b eu=%b et=%b eo=%b want all 0",
               handler_enable, handler_data, busy, cmd_done, error_unknown, error_timeout, error_overrun);
    end
    $display("txn reset released");
  endtask

  task automatic test_watchdog();
    drive_byte(8'h57);
    checks++;
    if (busy !== 1'b1 || handler_enable !== 4'b0000) begin
      errors++;
      $display("FAIL wd_opcode got busy=%b en=%b want busy=1 en=0000", busy, handler_enable);
    end
    data_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = sig[i];
      tick();
      checks++;
      if (handler_enable !== 4'b0001 || handler_data !== sig[i] || busy !== 1'b1) begin
        errors++;
        $display("FAIL wd_strobe%0d got en=%b data=%h busy=%b want en=0001 data=%h busy=1",
                 i, handler_enable, handler_data, busy, sig[i]);
      end
      $display("txn watchdog payload byte %0d = %h en=%b", i, handler_data, handler_enable);
    end
    data_valid = 1'b0;
    tick();
    checks++;
    if (handler_enable !== 4'b0000 || busy !== 1'b1 || cmd_done !== 1'b0) begin
      errors++;
      $display("FAIL wd_wait got en=%b busy=%b done=%b want en=0000 busy=1 done=0",
               handler_enable, busy, cmd_done);
    end
    handler_done = 4'b0001;
    tick();
    handler_done = 4'b0000;
    checks++;
    if (cmd_done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wd_done got done=%b busy=%b want done=1 busy=0", cmd_done, busy);
    end
    tick();
    checks++;
    if (cmd_done !== 1'b0) begin
      errors++;
      $display("FAIL wd_done_pulse got done=%b want 0", cmd_done);
    end
    $display("txn watchdog command complete");
  endtask

  task automatic test_unknown();
    drive_byte(8'hFF);
    checks++;
    if (error_unknown !== 1'b1 || busy !== 1'b0 || handler_enable !== 4'b0000) begin
      errors++;
      $display("FAIL unknown_pulse got eu=%b busy=%b en=%b want eu=1 busy=0 en=0000",
               error_unknown, busy, handler_enable);
    end
    tick();
    checks++;
    if (error_unknown !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL unknown_clear got eu=%b busy=%b want eu=0 busy=0", error_unknown, busy);
    end
    $display("txn unknown opcode ff");
  endtask

  task automatic test_misrouted_overrun();
    drive_byte(8'h57);
    for (int i = 0; i < 4; i++) drive_byte(sig[3-i]);
    tick();
    handler_done = 4'b0010;
    tick();
    handler_done = 4'b0000;
    checks++;
    if (cmd_done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL misrouted_done got done=%b busy=%b want done=0 busy=1", cmd_done, busy);
    end
    $display("txn misrouted done on slot 1 ignored");
    drive_byte(8'h99);
    checks++;
    if (error_overrun !== 1'b1 || busy !== 1'b1 || handler_enable !== 4'b0000) begin
      errors++;
      $display("FAIL overrun_pulse got eo=%b busy=%b en=%b want eo=1 busy=1 en=0000",
               error_overrun, busy, handler_enable);
    end
    handler_done = 4'b0001;
    tick();
    handler_done = 4'b0000;
    checks++;
    if (cmd_done !== 1'b1 || error_overrun !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL overrun_done got done=%b eo=%b busy=%b want done=1 eo=0 busy=0",
               cmd_done, error_overrun, busy);
    end
    $display("txn overrun then completion");
  endtask

  task automatic test_back_to_back();
    drive_byte(8'h57);
    for (int i = 0; i < 4; i++) drive_byte(sig[i]);
    handler_done = 4'b0001;
    data_in      = 8'h33;
    data_valid   = 1'b1;
    tick();
    handler_done = 4'b0000;
    checks++;
    if (cmd_done !== 1'b1 || error_overrun !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL simul_done_overrun got done=%b eo=%b busy=%b want done=1 eo=1 busy=0",
               cmd_done, error_overrun, busy);
    end
    data_in = 8'h41;
    tick();
    checks++;
    if (busy !== 1'b1 || error_unknown !== 1'b0) begin
      errors++;
      $display("FAIL next_opcode got busy=%b eu=%b want busy=1 eu=0", busy, error_unknown);
    end
    data_in = 8'h5A;
    tick();
    data_valid = 1'b0;
    checks++;
    if (handler_enable !== 4'b0010 || handler_data !== 8'h5A) begin
      errors++;
      $display("FAIL slot1_strobe got en=%b data=%h want en=0010 data=5a", handler_enable, handler_data);
    end
    handler_done = 4'b0010;
    tick();
    handler_done = 4'b0000;
    checks++;
    if (cmd_done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL slot1_done got done=%b busy=%b want done=1 busy=0", cmd_done, busy);
    end
    $display("txn back-to-back slot0 then slot1 complete");
  endtask

  task automatic test_reset_mid();
    logic saw;
    drive_byte(8'h57);
    drive_byte(8'h11);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({handler_enable, handler_data, busy, cmd_done, error_unknown, error_timeout, error_overrun} !== 19'd0) begin
      errors++;
      $display("FAIL midreset_outputs got en=%b data=%h busy=%b done=%b eu=%b et=%b eo=%b want all 0",
               handler_enable, handler_data, busy, cmd_done, error_unknown, error_timeout, error_overrun);
    end
    saw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (cmd_done || handler_enable != 4'b0000 || busy) saw = 1'b1;
    end
    checks++;
    if (saw !== 1'b0) begin
      errors++;
      $display("FAIL midreset_quiet got activity=%b want 0", saw);
    end
    drive_byte(8'h57);
    for (int i = 0; i < 4; i++) drive_byte(sig[i]);
    handler_done = 4'b0001;
    tick();
    handler_done = 4'b0000;
    checks++;
    if (cmd_done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_retry got done=%b busy=%b want done=1 busy=0", cmd_done, busy);
    end
    $display("txn reset mid-payload then full command");
  endtask

`ifdef CONTROL_CMD_DISPATCH_TIMEOUT_EN
  task automatic test_timeout();
    logic early;
    drive_byte(8'h57);
    drive_byte(8'h01);
    drive_byte(8'h02);
    early = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (error_timeout) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL tmo_early got early=%b busy=%b want early=0 busy=1", early, busy);
    end
    tick();
    checks++;
    if (error_timeout !== 1'b1 || busy !== 1'b0 || cmd_done !== 1'b0) begin
      errors++;
      $display("FAIL tmo_pulse got et=%b busy=%b done=%b want et=1 busy=0 done=0",
               error_timeout, busy, cmd_done);
    end
    $display("txn inter-byte timeout");
    drive_byte(8'h57);
    checks++;
    if (busy !== 1'b1 || error_timeout !== 1'b0) begin
      errors++;
      $display("FAIL tmo_reaccept got busy=%b et=%b want busy=1 et=0", busy, error_timeout);
    end
    for (int i = 0; i < 16; i++) tick();
    drive_byte(sig[0]);
    checks++;
    if (handler_enable !== 4'b0001 || handler_data !== sig[0] || error_timeout !== 1'b0) begin
      errors++;
      $display("FAIL tmo_edge_byte got en=%b data=%h et=%b want en=0001 data=%h et=0",
               handler_enable, handler_data, error_timeout, sig[0]);
    end
    for (int i = 1; i < 4; i++) drive_byte(sig[i]);
    handler_done = 4'b0001;
    tick();
    handler_done = 4'b0000;
    checks++;
    if (cmd_done !== 1'b1 || error_timeout !== 1'b0) begin
      errors++;
      $display("FAIL tmo_recover_done got done=%b et=%b want done=1 et=0", cmd_done, error_timeout);
    end
    $display("txn byte on timeout boundary accepted, command complete");
  endtask
`else
  task automatic test_timeout();
    logic fired;
    drive_byte(8'h57);
    drive_byte(8'h01);
    fired = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (error_timeout) fired = 1'b1;
    end
    checks++;
    if (fired !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL stall_wait got et=%b busy=%b want et=0 busy=1", fired, busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_reset got busy=%b want 0", busy);
    end
    $display("txn stalled payload waits until reset");
  endtask
`endif

  initial begin
    test_reset();
    test_watchdog();
    test_unknown();
    test_misrouted_overrun();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
